// File: rtl/snn_training_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : snn_training_sequencer_if
// Description : Pattern-memory, network and status bundle of the SNN
//               training sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface snn_training_sequencer_if;
    logic       start;
    logic [5:0] mem_addr;
    logic [5:0] mem_inp;
    logic [2:0] mem_exp;
    logic [5:0] net_inp;
    logic [2:0] net_outp;
    logic       learn_en;
    logic       busy;
    logic       done;
    logic [7:0] epoch;
    logic [5:0] match_count;
    logic [5:0] last_match;

    modport master (
        input  start, mem_inp, mem_exp, net_outp,
        output mem_addr, net_inp, learn_en, busy, done, epoch, match_count, last_match
    );

    modport slave (
        output start, mem_inp, mem_exp, net_outp,
        input  mem_addr, net_inp, learn_en, busy, done, epoch, match_count, last_match
    );
endinterface
`default_nettype wire

// File: rtl/snn_training_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : snn_training_sequencer
// Description : Epoch scheduler streaming stored patterns into the STDP network
//               with latency-aligned match scoring.
// Revision    : 1.0 - initial release
// ============================================================================
module snn_training_sequencer #(
    parameter int NUM_PATTERNS = 50,
    parameter int NUM_EPOCHS   = 218,
    parameter int PIPE_DELAY   = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    snn_training_sequencer_if.master     bus
);

    localparam logic [5:0] c_last_idx    = 6'(NUM_PATTERNS - 1);
    localparam logic [5:0] c_flush_last  = 6'(PIPE_DELAY);
    localparam logic [7:0] c_score_epoch = 8'(NUM_EPOCHS);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_RUN       = 3'd2,
        S_FLUSH     = 3'd3,
        S_EPOCH_END = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t           r_state;
    logic [5:0]       r_idx;
    logic [5:0]       r_mem_addr;
    logic [5:0]       r_net_inp;
    logic             r_learn_en;
    logic             r_busy;
    logic             r_done;
    logic [7:0]       r_epoch;
    logic [5:0]       r_match_count;
    logic [5:0]       r_last_match;
    // Expected-output delay line: index 0 is the head, PIPE_DELAY the tail.
    logic [PIPE_DELAY:0] r_dl_valid;
    logic [2:0]          r_dl_exp [PIPE_DELAY+1];

    logic w_score;

    assign w_score = r_dl_valid[PIPE_DELAY]
                  && (r_dl_exp[PIPE_DELAY] != 3'b000)
                  && (bus.net_outp == r_dl_exp[PIPE_DELAY]);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_idx         <= 6'd0;
            r_mem_addr    <= 6'd0;
            r_net_inp     <= 6'd0;
            r_learn_en    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_epoch       <= 8'd0;
            r_match_count <= 6'd0;
            r_last_match  <= 6'd0;
            r_dl_valid    <= '0;
            for (int k = 0; k <= PIPE_DELAY; k++) begin
                r_dl_exp[k] <= 3'b000;
            end
        end else begin
            // Invalid entries shift in unless RUN pushes a pattern below.
            r_dl_valid  <= {r_dl_valid[PIPE_DELAY-1:0], 1'b0};
            for (int k = PIPE_DELAY; k > 0; k--) begin
                r_dl_exp[k] <= r_dl_exp[k-1];
            end
            r_dl_exp[0] <= 3'b000;
            r_net_inp   <= 6'd0;

            if (w_score) begin
                r_match_count <= r_match_count + 6'd1;
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_state       <= S_FETCH;
                        r_epoch       <= 8'd0;
                        r_match_count <= 6'd0;
                        r_last_match  <= 6'd0;
                        r_done        <= 1'b0;
                        r_busy        <= 1'b1;
                        r_learn_en    <= 1'b1;
                        r_mem_addr    <= 6'd0;
                    end
                end

                S_FETCH: begin
                    r_state    <= S_RUN;
                    r_idx      <= 6'd0;
                    r_mem_addr <= 6'd1;
                end

                S_RUN: begin
                    r_net_inp     <= bus.mem_inp;
                    r_dl_valid[0] <= 1'b1;
                    r_dl_exp[0]   <= bus.mem_exp;
                    if (r_idx == c_last_idx) begin
                        r_state <= S_FLUSH;
                        r_idx   <= 6'd0;
                    end else begin
                        r_idx <= r_idx + 6'd1;
                        // Address runs one pattern ahead, parking on the last one.
                        if (r_idx + 6'd2 > c_last_idx) begin
                            r_mem_addr <= c_last_idx;
                        end else begin
                            r_mem_addr <= r_idx + 6'd2;
                        end
                    end
                end

                S_FLUSH: begin
                    if (r_idx == c_flush_last) begin
                        r_state <= S_EPOCH_END;
                        r_idx   <= 6'd0;
                    end else begin
                        r_idx <= r_idx + 6'd1;
                    end
                end

                S_EPOCH_END: begin
                    r_last_match  <= r_match_count;
                    r_match_count <= 6'd0;
                    if (r_epoch == c_score_epoch) begin
                        r_state    <= S_DONE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_learn_en <= 1'b0;
                    end else begin
                        r_state    <= S_FETCH;
                        r_epoch    <= r_epoch + 8'd1;
                        r_mem_addr <= 6'd0;
                        r_learn_en <= (r_epoch + 8'd1) < c_score_epoch;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_addr    = r_mem_addr;
    assign bus.net_inp     = r_net_inp;
    assign bus.learn_en    = r_learn_en;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.epoch       = r_epoch;
    assign bus.match_count = r_match_count;
    assign bus.last_match  = r_last_match;

endmodule
`default_nettype wire

// File: tb/tb_snn_training_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_snn_training_sequencer
// Description : Self-checking bench for snn_training_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snn_training_sequencer;

    localparam int N  = 6;
    localparam int NE = 2;
    localparam int P  = 2;
    localparam int L  = N + P + 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    snn_training_sequencer_if bus ();

    snn_training_sequencer #(
        .NUM_PATTERNS (N),
        .NUM_EPOCHS   (NE),
        .PIPE_DELAY   (P)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [5:0] pat  [64];
    logic [2:0] expv [64];
    logic [5:0] hist [8];
    int         net_lat     = 2;
    logic       corrupt_en  = 1'b0;
    logic [5:0] corrupt_val = 6'd0;
    int         vectors     = 0;
    int         miscompares = 0;

    // Network stand-in: decodes inputs[5:3], optionally corrupting one input value.
    function automatic logic [2:0] net_fn(input logic [5:0] x, input logic en, input logic [5:0] bad);
        return x[5:3] ^ ((en && x == bad) ? 3'b111 : 3'b000);
    endfunction

    always @(posedge clock) begin
        bus.mem_inp <= pat[bus.mem_addr];
        bus.mem_exp <= expv[bus.mem_addr];
        if (reset) begin
            for (int k = 0; k < 8; k++) hist[k] <= 6'd0;
        end else begin
            hist[0] <= bus.net_inp;
            for (int k = 1; k < 8; k++) hist[k] <= hist[k-1];
        end
    end

    always_comb bus.net_outp = net_fn(hist[net_lat-1], corrupt_en, corrupt_val);

    // Score of one epoch: pattern i is judged against what the network emits
    // PIPE_DELAY cycles after i appears, which stems from input i + P - lat.
    function automatic int ref_score(input int lat);
        int s;
        s = 0;
        for (int i = 0; i < N; i++) begin
            int j;
            logic [5:0] seen;
            j    = i + P - lat;
            seen = (j >= 0 && j < N) ? pat[j] : 6'd0;
            if (expv[i] != 3'b000 && expv[i] == net_fn(seen, corrupt_en, corrupt_val)) s++;
        end
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expct);
        vectors++;
        assert (obs === expct) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expct);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".mem_addr"},    32'(bus.mem_addr),    32'd0);
        check({tag, ".net_inp"},     32'(bus.net_inp),     32'd0);
        check({tag, ".learn_en"},    32'(bus.learn_en),    32'd0);
        check({tag, ".busy"},        32'(bus.busy),        32'd0);
        check({tag, ".done"},        32'(bus.done),        32'd0);
        check({tag, ".epoch"},       32'(bus.epoch),       32'd0);
        check({tag, ".match_count"}, 32'(bus.match_count), 32'd0);
        check({tag, ".last_match"},  32'(bus.last_match),  32'd0);
    endtask

    // Full run from an accepted start to DONE, checked cycle by cycle.
    task automatic run(input int exp_score, input bit poke);
        int last_c;
        int ep;
        int ph;
        logic [5:0] exp_inp;
        logic [5:0] exp_addr;
        last_c    = (NE + 1) * L + 1;
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        for (int c = 1; c <= last_c; c++) begin
            ep = (c - 1) / L;
            ph = (c - 1) % L;
            if (c == last_c) begin
                check("done_at_end",   32'(bus.done),        32'd1);
                check("busy_at_end",   32'(bus.busy),        32'd0);
                check("epoch_at_end",  32'(bus.epoch),       32'(NE));
                check("learn_at_end",  32'(bus.learn_en),    32'd0);
                check("score_at_end",  32'(bus.last_match),  32'(exp_score));
                check("count_at_end",  32'(bus.match_count), 32'd0);
            end else begin
                exp_inp = (ph >= 2 && ph <= N + 1) ? pat[ph-2] : 6'd0;
                check("done_low",  32'(bus.done),     32'd0);
                check("busy_high", 32'(bus.busy),     32'd1);
                check("epoch",     32'(bus.epoch),    32'(ep));
                check("learn_en",  32'(bus.learn_en), 32'(ep < NE));
                check("net_inp",   32'(bus.net_inp),  32'(exp_inp));
                if (ph <= N) begin
                    exp_addr = (ph == 0) ? 6'd0 : ((ph < N) ? 6'(ph) : 6'(N - 1));
                    check("mem_addr", 32'(bus.mem_addr), 32'(exp_addr));
                end
                if (ph == 0)
                    check("count_cleared", 32'(bus.match_count), 32'd0);
                if (ph == 0 && ep > 0)
                    check("last_match", 32'(bus.last_match), 32'(exp_score));
                if (ph == L - 1)
                    check("count_final", 32'(bus.match_count), 32'(exp_score));
                bus.start = (poke && c == 5);
                @(posedge clock); #1;
            end
        end
        bus.start = 1'b0;
        @(posedge clock); #1;
        check("done_holds",  32'(bus.done),       32'd1);
        check("score_holds", 32'(bus.last_match), 32'(exp_score));
    endtask

    initial begin
        bus.start = 1'b0;
        for (int k = 0; k < 64; k++) begin
            pat[k]  = 6'd0;
            expv[k] = 3'd0;
        end
        repeat (3) @(posedge clock);
        #1;
        check_reset_state("reset");
        reset = 1'b0;
        @(posedge clock); #1;

        // Directed one-hot set; index 3 expects 000 and must never score.
        pat[0] = 6'b100000; expv[0] = 3'b100;
        pat[1] = 6'b010000; expv[1] = 3'b010;
        pat[2] = 6'b001000; expv[2] = 3'b001;
        pat[3] = 6'b000000; expv[3] = 3'b000;
        pat[4] = 6'b100001; expv[4] = 3'b100;
        pat[5] = 6'b011000; expv[5] = 3'b011;
        net_lat = 2;
        run(5, 1'b1);

        corrupt_en  = 1'b1;
        corrupt_val = 6'b010000;
        run(4, 1'b0);

        corrupt_en = 1'b0;
        net_lat    = 1;
        run(0, 1'b0);

        // Reset in the middle of epoch 1 with start held high.
        net_lat   = 2;
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (L + 3) @(posedge clock);
        #1;
        check("midrun_epoch", 32'(bus.epoch), 32'd1);
        reset     = 1'b1;
        bus.start = 1'b1;
        @(posedge clock); #1;
        check_reset_state("midrun_reset");
        @(posedge clock); #1;
        check("reset_start_ignored", 32'(bus.busy), 32'd0);
        reset     = 1'b0;
        bus.start = 1'b0;
        @(posedge clock); #1;
        check_reset_state("idle_after_reset");

        for (int r = 0; r < 4; r++) begin
            net_lat = $urandom_range(1, 3);
            for (int i = 0; i < N; i++) begin
                pat[i]  = 6'($urandom);
                expv[i] = ($urandom_range(0, 3) != 0) ? pat[i][5:3] : 3'($urandom);
            end
            corrupt_en  = 1'($urandom_range(0, 1));
            corrupt_val = pat[$urandom_range(0, N - 1)];
            run(ref_score(net_lat), r[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/snn_training_sequencer.md
# snn_training_sequencer

Epoch scheduler for the 6-input / 3-output spiking network with STDP training. Streams a stored pattern set into the network for a configurable number of training epochs with learning enabled, then runs one scoring epoch with learning frozen. Aligns each expected output to the network's pipeline latency and counts matches per epoch. Replaces the hand-written stimulus loop as the on-chip driver of the training network.

## Interface
- NUM_PATTERNS, 50, patterns per epoch (2..63)
- NUM_EPOCHS, 218, training epochs before the scoring epoch (1..255)
- PIPE_DELAY, 2, network latency in cycles from inputs to decoded outputs (1..7)

- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin a run; sampled only in IDLE
- mem_addr  out  6  pattern memory read address
- mem_inp  in  6  input pattern; synchronous memory, valid 1 cycle after mem_addr
- mem_exp  in  3  expected output for the same address, same latency
- net_inp  out  6  registered drive to network inp_1..inp_6 (bit 5 = inp_1)
- net_outp  in  3  network outp_1..outp_3 (bit 2 = outp_1)
- learn_en  out  1  STDP weight-update enable to network
- busy  out  1  high from the cycle after start until DONE is entered
- done  out  1  level; high in DONE until the next accepted start or reset
- epoch  out  8  current epoch index, 0-based; scoring epoch = NUM_EPOCHS
- match_count  out  6  scored matches so far in current epoch
- last_match  out  6  final match_count of the most recently completed epoch

## Operation
- States: IDLE, FETCH, RUN, FLUSH, EPOCH_END, DONE.
- IDLE: start=1 -> FETCH; epoch, match_count, last_match cleared, done cleared.
- FETCH (1 cycle): mem_addr=0.
- RUN (NUM_PATTERNS cycles, index i=0..NUM_PATTERNS-1): mem_addr=i+1 (held at NUM_PATTERNS-1 on last cycle); at cycle end net_inp<=mem_inp (pattern i) and {valid=1, mem_exp} pushed into expected delay line.
- FLUSH (PIPE_DELAY+1 cycles): net_inp<=0, invalid entries pushed.
- Delay line depth PIPE_DELAY+1: exp for pattern i reaches the tail at the clock edge ending cycle T_i+PIPE_DELAY, where T_i is the first cycle pattern i is visible on net_inp.
- Scoring: at each edge where the tail is valid, tail exp != 3'b000 and net_outp == tail exp, match_count increments. All-zero expected patterns are never scored. match_count cannot exceed NUM_PATTERNS; no saturation logic required.
- EPOCH_END (1 cycle): last_match<=match_count (including any increment on the final FLUSH edge), match_count<=0; if epoch==NUM_EPOCHS -> DONE, else epoch+1, -> FETCH.
- learn_en = 1 in FETCH/RUN/FLUSH/EPOCH_END while epoch<NUM_EPOCHS; 0 during the scoring epoch, IDLE and DONE.
- DONE: net_inp=0, epoch holds NUM_EPOCHS, last_match holds score; start=1 -> behaves as from IDLE.
- start while busy ignored.

## Timing
- Reset values: mem_addr=0, net_inp=0, learn_en=0, busy=0, done=0, epoch=0, match_count=0, last_match=0, delay line all invalid, state IDLE.
- Reset mid-run: all of the above on next edge; no partial score retained.
- Start accepted at edge E: state FETCH in cycle after E; pattern 0 visible on net_inp 2 cycles after E.
- Epoch length: NUM_PATTERNS+PIPE_DELAY+3 cycles (55 at defaults); full run (NUM_EPOCHS+1)×that + 1 cycle to reach DONE.
- Epoch boundary: net_inp is 0 for PIPE_DELAY+3 consecutive cycles between last pattern of one epoch and pattern 0 of the next.
- learn_en falls on the edge entering the scoring epoch's FETCH.

## Test plan
- Reset: assert reset mid-RUN of epoch 1 -> next cycle all outputs at reset values, state IDLE, start ignored while reset high.
- Single epoch, NUM_PATTERNS=4, NUM_EPOCHS=1, PIPE_DELAY=2, network model = inputs[5:3] delayed 2 cycles, patterns 6'b100000,6'b010000,6'b001000,6'b000000 with exp 3'b100,3'b010,3'b001,3'b000 -> last_match=3 after each epoch, done after 2×9+1 cycles.
- Mismatch: same set, model corrupts pattern 1 -> last_match=2; expected 3'b000 pattern matched by output 000 never counted.
- Latency: PIPE_DELAY=1 with 1-cycle model -> full score; PIPE_DELAY=2 with 1-cycle model -> score 0.
- learn_en: NUM_EPOCHS=2 -> learn_en high for epochs 0-1, low for epoch 2 exactly, epoch reads 2 in DONE.
- start while busy pulsed at cycle 5 -> no restart, epoch count unaffected; start in DONE -> new run, done cleared next cycle.
